// File: rtl/popcount23_tneuron_seq_if.sv
// Chunk-in / result-out bus of the ternary neuron sequencer.
//
// Valid/ready: a transfer happens on a rising clock edge where both valid
// and ready are high. A source holds valid and its payload stable until
// that edge. A sink may raise or lower ready at any time. Valid never
// depends combinationally on ready.
interface popcount23_tneuron_seq_if #(
  parameter int ACC_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [22:0]      in_x;
  logic [22:0]      in_wp;
  logic [22:0]      in_wn;
  logic             in_last;
  logic [ACC_W-1:0] in_thr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_fire;
  logic             out_ovf;

  // Environment side: feeds chunks, consumes results
  modport master (
    output in_valid, in_x, in_wp, in_wn, in_last, in_thr, out_ready,
    input  in_ready, out_valid, out_sum, out_fire, out_ovf
  );

  // Sequencer side
  modport slave (
    input  in_valid, in_x, in_wp, in_wn, in_last, in_thr, out_ready,
    output in_ready, out_valid, out_sum, out_fire, out_ovf
  );
endinterface

// File: rtl/popcount23_tneuron_seq.sv
// Ternary neuron sequencer. One shared 23-input popcount unit is used twice
// per chunk (positive mask, then negative mask); the signed saturating sum
// over up to MAX_CHUNKS chunks is returned with a threshold-fire bit.
module popcount23_tneuron_seq #(
  parameter int MAX_CHUNKS = 4,
  parameter int ACC_W      = 8,
  parameter int CNT_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  popcount23_tneuron_seq_if.slave bus,
  output logic [22:0]             pc_in,
  input  logic [4:0]              pc_out,
  output logic [1:0]              o_dbg_state
);

  localparam int EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 <<< (ACC_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(1 <<< (ACC_W - 1)));
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAX_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POS  = 2'd1,
    S_NEG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_thr;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0]        r_cnt;
  logic [22:0]             r_x;
  logic [22:0]             r_wp;
  logic [22:0]             r_wn;
  logic                    r_last;
  logic                    r_ovf;
  logic                    r_out_valid;
  logic                    r_out_fire;
  logic                    r_in_ready;

  logic                    w_end_eval;
  logic signed [EXT_W-1:0] w_acc_ext;
  logic signed [EXT_W-1:0] w_pc_ext;
  logic signed [EXT_W-1:0] w_sum_ext;
  logic signed [ACC_W-1:0] w_acc_sat;

  // Evaluation ends on the flagged last chunk or when the chunk budget runs out
  assign w_end_eval = r_last | (r_cnt == CNT_LAST);

  // Operands widened by two bits so +/-23 on a full accumulator cannot wrap
  assign w_acc_ext = $signed({{2{r_acc[ACC_W-1]}}, r_acc});
  assign w_pc_ext  = $signed({{(EXT_W-5){1'b0}}, pc_out});

  // Saturating add in POS, saturating subtract in NEG
  always_comb begin
    w_sum_ext = w_acc_ext + w_pc_ext;
    if (r_state == S_NEG) begin
      w_sum_ext = w_acc_ext - w_pc_ext;
    end
    w_acc_sat = w_sum_ext[ACC_W-1:0];
    if (w_sum_ext > SAT_MAX) begin
      w_acc_sat = SAT_MAX[ACC_W-1:0];
    end else if (w_sum_ext < SAT_MIN) begin
      w_acc_sat = SAT_MIN[ACC_W-1:0];
    end
  end

  // Next state and the popcount operand mux
  always_comb begin
    w_next_state = r_state;
    pc_in        = 23'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) w_next_state = S_POS;
      end
      S_POS: begin
        pc_in        = r_x & r_wp;
        w_next_state = S_NEG;
      end
      S_NEG: begin
        pc_in        = r_x & r_wn;
        w_next_state = w_end_eval ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (bus.out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Chunk capture, accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_thr       <= '0;
      r_x         <= '0;
      r_wp        <= '0;
      r_wn        <= '0;
      r_last      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_fire  <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x    <= bus.in_x;
            r_wp   <= bus.in_wp;
            r_wn   <= bus.in_wn;
            r_last <= bus.in_last;
            if (r_cnt == '0) begin
              r_thr <= $signed(bus.in_thr);
              r_acc <= '0;
            end
          end
        end
        S_POS: begin
          r_acc <= w_acc_sat;
        end
        S_NEG: begin
          r_acc <= w_acc_sat;
          if (w_end_eval) begin
            r_cnt      <= '0;
            r_ovf      <= ~r_last;
            r_out_sum  <= w_acc_sat;
            r_out_fire <= (w_acc_sat >= r_thr);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_fire  = r_out_fire;
  assign bus.out_ovf   = r_ovf;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/popcount23_tneuron_seq.md
Name: popcount23_tneuron_seq

Overview:
- Sequencer for one ternary neuron built on a single shared 23-input popcount unit (exact or approximate variant).
- Accepts a stream of 23-bit activation chunks with positive and negative weight masks.
- Time-multiplexes the popcount between the positive and negative masks, then accumulates a signed sum over a chunked input vector.
- Emits the sum and a threshold-fire bit through a valid/ready handshake. Sits between the sensor input buffer and the layer output register.

Parameters:
- MAX_CHUNKS, 4, maximum chunks per neuron evaluation (≥1).
- ACC_W, 8, signed accumulator/threshold width (two's complement).
- CNT_W, 2, chunk counter width; must satisfy 2^CNT_W ≥ MAX_CHUNKS.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  chunk available.
- in_ready  out  1  chunk accepted when in_valid & in_ready.
- in_x  in  23  activation bits.
- in_wp  in  23  positive-weight mask.
- in_wn  in  23  negative-weight mask.
- in_last  in  1  final chunk of this neuron.
- in_thr  in  ACC_W  signed fire threshold; sampled on the first chunk of an evaluation only.
- pc_in  out  23  operand to the external popcount unit.
- pc_out  in  5  popcount result; combinational return, same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_sum  out  ACC_W  signed accumulated sum.
- out_fire  out  1  out_sum ≥ threshold (signed compare).
- out_ovf  out  1  evaluation was truncated at MAX_CHUNKS without in_last.

Behaviour:
- The FSM has four states: IDLE, POS, NEG, DONE. Reset forces IDLE and clears the following to 0: acc, chunk counter, thr_r, x_r, wp_r, wn_r, last_r, ovf_r, out_valid, out_sum, out_fire, out_ovf, pc_in. Reset mid-evaluation discards the partial sum.
- IDLE:
  - in_ready=1; pc_in=0.
  - On accept, register x/wp/wn/last. If the chunk counter is 0, also register thr_r=in_thr and clear acc. Go to POS.
- POS:
  - pc_in = x_r & wp_r.
  - acc ← sat(acc + pc_out). Go to NEG.
- NEG:
  - pc_in = x_r & wn_r.
  - acc ← sat(acc − pc_out).
  - If last_r, or counter = MAX_CHUNKS−1: go to DONE and counter ← 0. ovf_r ← (¬last_r).
  - Otherwise counter++ and go to IDLE.
- DONE:
  - out_valid=1; in_ready=0; pc_in=0.
  - out_sum, out_fire and out_ovf are registered on entry and held stable while out_valid is high.
  - On out_ready, go to IDLE, drop out_valid the next cycle, and clear ovf_r.
- in_ready is 1 only in IDLE. Throughput is 3 cycles per chunk minimum. Latency from the last chunk accept to out_valid is 3 cycles.
- pc_out is only sampled in POS/NEG. The unit must tolerate approximate pc_out (up to 23), with no assertion on consistency.
- Arithmetic:
  - pc_out is zero-extended to ACC_W.
  - sat() clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1] and never wraps.
  - out_fire compares the signed sum against the signed thr_r.
- While in POS/NEG/DONE, in_valid is ignored and inputs may change freely. Registered copies are used throughout.
- Simultaneous out_ready and in_valid in DONE: no chunk is accepted that cycle. The next chunk is accepted in IDLE one cycle later.
- pc_in is the only output driven combinationally from state. All other outputs are registered.

Test Plan:
- Single chunk, in_last=1: x=all ones, wp=0x0000FF (8 bits), wn=0x000F00 (4 bits), thr=3, exact popcount model → out_sum=4, out_fire=1, out_ovf=0. out_valid rises 3 cycles after accept.
- Three chunks: each has x=0x7FFFFF, wp=0, wn=0x00001F, thr=−10, last on the third chunk → out_sum=−15, out_fire=0. Check that in_ready is low in POS/NEG. Check that thr is sampled only on chunk 1 by changing in_thr on chunks 2–3 with no effect.
- Truncation: feed 5 chunks with in_last=0, each contributing +1 → result after chunk 4 has out_sum=4 and out_ovf=1. The fifth chunk starts a new evaluation with acc cleared.
- Saturation with ACC_W=6, MAX_CHUNKS=4: four chunks of +23 → out_sum=31, not wrapped. Four chunks of −23 → out_sum=−32.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 → out_valid and out_sum stable, no chunk accepted. Release → out_valid low next cycle, chunk accepted the cycle after.
- Reset in NEG of chunk 2: assert rst for one cycle → all outputs 0, in_ready=1. A new single-chunk evaluation gives a sum unaffected by the aborted one.
